// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// The frame helper packs the bits in wire order: d0..d7, odd parity, stop.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int FRAME_BITS         = 10;
  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_TIMEOUT_CYCLES = 375000;

  // The stop position is a 1 so that driving ~bit releases the data line.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, plus a
// falling-edge strobe on the synchronized clock. Flops reset to the idle level.
module ps2_line_sync (
  input  logic clk,
  input  logic nreset,
  input  logic c_raw,
  input  logic d_raw,
  output logic c_sync,
  output logic d_sync,
  output logic fall
);

  logic c_p0, c_p1, c_p2;
  logic d_p0, d_p1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      c_p0 <= 1'b1;
      c_p1 <= 1'b1;
      c_p2 <= 1'b1;
      d_p0 <= 1'b1;
      d_p1 <= 1'b1;
    end else begin
      c_p0 <= c_raw;
      c_p1 <= c_p0;
      c_p2 <= c_p1;
      d_p0 <= d_raw;
      d_p1 <= d_p0;
    end
  end

  assign c_sync = c_p1;
  assign d_sync = d_p1;
  assign fall   = c_p2 & ~c_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// one byte plus parity and stop on device clock falls, then check the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(FRAME_BITS - 1);

  ps2_state_t            state, state_nxt;
  logic [IW-1:0]         inh_cnt, inh_nxt;
  logic [TW-1:0]         to_cnt, to_nxt;
  logic [3:0]            bit_idx, idx_nxt;
  logic                  dbit, dbit_nxt;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  load;
  logic                  c_oe, d_oe, done, err;
  logic                  c_sync, d_sync, fall;
  logic                  active, timeout;

  ps2_line_sync u_sync (
    .clk    (clk),
    .nreset (nreset),
    .c_raw  (ps2c_in),
    .d_raw  (ps2d_in),
    .c_sync (c_sync),
    .d_sync (d_sync),
    .fall   (fall)
  );

  assign active  = (state == RTS) || (state == SHIFT) ||
                   (state == ACK) || (state == WAIT_IDLE);
  assign timeout = active && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      inh_cnt <= '0;
      to_cnt  <= '0;
      bit_idx <= '0;
      dbit    <= 1'b0;
    end else begin
      state   <= state_nxt;
      inh_cnt <= inh_nxt;
      to_cnt  <= to_nxt;
      bit_idx <= idx_nxt;
      dbit    <= dbit_nxt;
    end
  end

  // Frame contents are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      frame_q <= build_frame(tx_data);
    end
  end

  always_comb begin
    state_nxt = state;
    inh_nxt   = '0;
    idx_nxt   = bit_idx;
    dbit_nxt  = dbit;
    load      = 1'b0;
    c_oe      = 1'b0;
    d_oe      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          load      = 1'b1;
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        c_oe = 1'b1;
        if (inh_cnt == INH_LAST) begin
          d_oe      = 1'b1;
          state_nxt = RTS;
        end else begin
          inh_nxt = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        // The fall that ends request-to-send is also the slot for d0.
        d_oe = 1'b1;
        if (fall) begin
          dbit_nxt  = ~frame_q[bit_idx];
          idx_nxt   = bit_idx + 4'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        d_oe = dbit;
        if (fall) begin
          dbit_nxt = ~frame_q[bit_idx];
          if (bit_idx == LAST_IDX) begin
            state_nxt = ACK;
          end else begin
            idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ACK: begin
        if (fall) begin
          if (d_sync) begin
            err       = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (c_sync && d_sync) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Timeout overrides any ACK outcome in the same cycle.
    if (timeout) begin
      state_nxt = IDLE;
      d_oe      = 1'b0;
      done      = 1'b0;
      err       = 1'b1;
    end

    if (state_nxt == IDLE) begin
      idx_nxt  = '0;
      dbit_nxt = 1'b0;
    end

    to_nxt = (active && (state_nxt != IDLE)) ? to_cnt + 1'b1 : '0;
  end

  assign ps2c_oe  = c_oe;
  assign ps2d_oe  = d_oe;
  assign busy     = (state != IDLE);
  assign tx_done  = done;
  assign tx_error = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and each scenario task checks the wire bits and completion pulses.
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TO   = 3000;
  localparam int LOW  = 15;
  localparam int HIGH = 15;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, tx_done, tx_error;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Open-drain wire: low if either side pulls.
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  always #20 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  always @(negedge clk) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation still running after 90000 cycles, required to finish");
    $fatal(1);
  end

  // Expected wire bits: data LSB first, then a parity making the ones count odd, then stop high.
  function automatic logic [9:0] frame_model(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side: wait for inhibit then RTS, then generate npulses clock pulses,
  // sampling data late in each low phase and answering the 11th with ack.
  task automatic dev_frame(input bit ack, input int npulses, output logic [9:0] got,
                           output bit start_ok, output bit timed_out);
    int w;
    got = '0;
    start_ok = 1'b0;
    timed_out = 1'b0;
    w = 0;
    while (ps2c_in !== 1'b0 && w < 6000) begin @(negedge clk); w++; end
    if (w >= 6000) begin timed_out = 1'b1; return; end
    w = 0;
    while (ps2c_in === 1'b0 && w < 6000) begin @(negedge clk); w++; end
    if (w >= 6000) begin timed_out = 1'b1; return; end
    start_ok = (ps2d_in === 1'b0);
    tick(10);
    for (int k = 1; k <= npulses; k++) begin
      if (k == 11) begin dev_d_low = ack; tick(5); end
      dev_c_low = 1'b1;
      tick(LOW);
      if (k <= 10) got[k-1] = ps2d_in;
      dev_c_low = 1'b0;
      tick(HIGH);
      if (k == 11) dev_d_low = 1'b0;
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    tick(3);
    n_checks++;
    if ({ps2c_oe, ps2d_oe, busy, tx_done, tx_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_held: outputs %b, required 00000", {ps2c_oe, ps2d_oe, busy, tx_done, tx_error});
    end
    nreset = 1'b1;
    tick(5);
    n_checks++;
    if ({ps2c_oe, ps2d_oe, busy, tx_done, tx_error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_released: outputs %b, required 00000", {ps2c_oe, ps2d_oe, busy, tx_done, tx_error});
    end
    n_checks++;
    if (done_cnt + err_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_pulses: %0d pulses, required 0", done_cnt + err_cnt);
    end
  endtask

  task automatic test_send_ed;
    int d0, e0;
    logic [9:0] got;
    bit st, tmo;
    logic b1, c1;
    d0 = done_cnt; e0 = err_cnt;
    fork
      begin start_tx(8'hED); b1 = busy; c1 = ps2c_oe; end
      dev_frame(1'b1, 11, got, st, tmo);
    join
    tick(20);
    n_checks++;
    if ({b1, c1} !== 2'b11) begin
      n_fail++;
      $display("FAIL ed_busy_rise: busy,ps2c_oe=%b after start, required 11", {b1, c1});
    end
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL ed_dev_wait: device wait expired, required frame"); end
    n_checks++;
    if (got !== 10'b1_1_11101101) begin
      n_fail++;
      $display("FAIL ed_bits: wire %b, required %b", got, 10'b1_1_11101101);
    end
    n_checks++;
    if (got !== frame_model(8'hED)) begin
      n_fail++;
      $display("FAIL ed_model: wire %b, required %b", got, frame_model(8'hED));
    end
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL ed_pulses: done=%0d err=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
    end
    n_checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL ed_idle: busy,c_oe,d_oe=%b, required 000", {busy, ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_send_f4;
    int d0, inh_len, start_cycles, w;
    logic [9:0] got;
    bit st, tmo;
    logic last_d, rts_d;
    d0 = done_cnt;
    inh_len = 0; start_cycles = 0; w = 0; last_d = 1'b0; rts_d = 1'b0;
    fork
      start_tx(8'hF4);
      dev_frame(1'b1, 11, got, st, tmo);
      begin
        while (!ps2c_oe && w < 100) begin @(negedge clk); w++; end
        while (ps2c_oe && inh_len < 10000) begin
          inh_len++;
          if (ps2d_oe) start_cycles++;
          last_d = ps2d_oe;
          @(negedge clk);
        end
        rts_d = ps2d_oe;
      end
    join
    tick(20);
    n_checks++;
    if (inh_len !== INH) begin
      n_fail++;
      $display("FAIL f4_inhibit_len: %0d cycles, required %0d", inh_len, INH);
    end
    n_checks++;
    if ({start_cycles == 1, last_d, rts_d} !== 3'b111) begin
      n_fail++;
      $display("FAIL f4_start_bit: overlap=%0d last=%b rts=%b, required 1/1/1", start_cycles, last_d, rts_d);
    end
    n_checks++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL f4_start_seen: data at release %b, required low", ~st); end
    n_checks++;
    if (got !== 10'b1_0_11110100) begin
      n_fail++;
      $display("FAIL f4_bits: wire %b, required %b", got, 10'b1_0_11110100);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL f4_done: %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_nack;
    int d0, e0;
    logic [9:0] got;
    bit st, tmo;
    logic [7:0] b;
    b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt;
    fork
      start_tx(b);
      dev_frame(1'b0, 11, got, st, tmo);
    join
    tick(20);
    n_checks++;
    if (got !== frame_model(b)) begin
      n_fail++;
      $display("FAIL nack_bits: wire %b, required %b", got, frame_model(b));
    end
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL nack_pulses: done=%0d err=%0d, required 0/1", done_cnt - d0, err_cnt - e0);
    end
    n_checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL nack_idle: busy,c_oe,d_oe=%b, required 000", {busy, ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_timeout;
    int d0, e0, w, n, err_at;
    logic rts_d;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'($urandom));
    w = 0;
    while ((!busy || ps2c_oe) && w < 6000) begin @(negedge clk); w++; end
    rts_d = ps2d_oe;
    n = 0; err_at = -1;
    while (busy && n < TO + 100) begin
      if (tx_error) err_at = n;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rts_d !== 1'b1) begin n_fail++; $display("FAIL to_rts_data: d_oe %b at release, required 1", rts_d); end
    n_checks++;
    if (n !== TO) begin
      n_fail++;
      $display("FAIL to_busy_len: busy fell %0d cycles after release, required %0d", n, TO);
    end
    n_checks++;
    if (err_at !== TO - 1) begin
      n_fail++;
      $display("FAIL to_pulse_at: error pulse at cycle %0d, required %0d", err_at, TO - 1);
    end
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL to_pulses: done=%0d err=%0d, required 0/1", done_cnt - d0, err_cnt - e0);
    end
    n_checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_release: c_oe,d_oe=%b, required 00", {ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [9:0] got;
    bit st, tmo;
    d0 = done_cnt; e0 = err_cnt;
    fork
      start_tx(8'h00);
      dev_frame(1'b1, 5, got, st, tmo);
    join
    n_checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_mid_before: busy,c_oe,d_oe=%b at bit 4, required 101", {busy, ps2c_oe, ps2d_oe});
    end
    #7 nreset = 1'b0;
    #1;
    n_checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_async: busy,c_oe,d_oe=%b right after reset, required 000", {busy, ps2c_oe, ps2d_oe});
    end
    @(negedge clk);
    tick(3);
    nreset = 1'b1;
    tick(5);
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_pulses: done=%0d err=%0d, required 0/0", done_cnt - d0, err_cnt - e0);
    end
    fork
      start_tx(8'h01);
      dev_frame(1'b1, 11, got, st, tmo);
    join
    tick(20);
    n_checks++;
    if (got !== 10'b1_0_00000001) begin
      n_fail++;
      $display("FAIL rst_mid_resend_bits: wire %b, required %b", got, 10'b1_0_00000001);
    end
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_resend_pulses: done=%0d err=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_ignore_start;
    int d0, e0;
    logic [9:0] got;
    bit st, tmo;
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hAA) b = 8'h55;
    d0 = done_cnt; e0 = err_cnt;
    fork
      start_tx(b);
      dev_frame(1'b1, 11, got, st, tmo);
      begin tick(200); start_tx(8'hAA); tick(2450); start_tx(8'hAA); end
    join
    tick(40);
    n_checks++;
    if (got !== frame_model(b)) begin
      n_fail++;
      $display("FAIL ign_bits: wire %b, required %b", got, frame_model(b));
    end
    n_checks++;
    if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL ign_pulses: done=%0d err=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_restart: busy %b, required 0", busy); end
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 4; it++) begin
      int d0, e0, w;
      logic [9:0] got;
      bit st, tmo, ack;
      logic [7:0] b;
      logic late_busy;
      b = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      d0 = done_cnt; e0 = err_cnt; w = 0; late_busy = 1'b1;
      fork
        start_tx(b);
        dev_frame(ack, 11, got, st, tmo);
        begin
          while (!(tx_done || tx_error) && w < 8000) begin @(negedge clk); w++; end
          tx_data  = ~b;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start  = 1'b0;
          late_busy = busy;
        end
      join
      tick(5);
      n_checks++;
      if (got !== frame_model(b)) begin
        n_fail++;
        $display("FAIL b2b_bits[%0d]: wire %b, required %b", it, got, frame_model(b));
      end
      n_checks++;
      if ({done_cnt - d0, err_cnt - e0} !== {32'(ack), 32'(!ack)}) begin
        n_fail++;
        $display("FAIL b2b_pulses[%0d]: done=%0d err=%0d, required %0d/%0d", it, done_cnt - d0,
                 err_cnt - e0, ack, !ack);
      end
      n_checks++;
      if ({w < 8000, late_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL b2b_start_on_pulse[%0d]: waited %0d busy %b, required pulse seen and busy 0",
                 it, w, late_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL pulse_exclusive: %0d cycles with both pulses, required 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
